// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam logic [4:0]  REG_X0      = 5'd0;
    localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for hazard statistics.
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect, memory wait.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_MemRead,
    input  logic       branch_taken,
    input  logic       mem_busy,
    output logic       pc_write_en,
    output logic       if_id_write_en,
    output logic       id_ex_write_en,
    output logic       ex_mem_write_en,
    output logic       mem_wb_write_en,
    output logic       if_id_flush,
    output logic       ctrl_mux_sel,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 state, state_next;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_next;
    logic                   load_use;
    logic                   stall_evt;
    logic                   back_en;

    assign load_use = ex_MemRead && (ex_rd != REG_X0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pc_write_en  = 1'b1;
        if_id_write_en = 1'b1;
        back_en      = 1'b1;
        if_id_flush  = 1'b0;
        ctrl_mux_sel = 1'b1;
        stall_evt    = 1'b0;

        if (reset) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            back_en        = 1'b0;
            if_id_flush    = 1'b1;
            ctrl_mux_sel   = 1'b0;
        end else if (mem_busy) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            back_en        = 1'b0;
        end else begin
            case (state)
                RUN, LOAD_STALL: begin
                    // load_use only counts in RUN so a stall never repeats back-to-back
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        ctrl_mux_sel = 1'b0;
                        if (FLUSH_CYCLES > 1) begin
                            cnt_next   = FLUSH_RELOAD;
                            state_next = FLUSH;
                        end else begin
                            state_next = RUN;
                        end
                    end else if ((state == RUN) && load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        ctrl_mux_sel   = 1'b0;
                        stall_evt      = 1'b1;
                        state_next     = LOAD_STALL;
                    end else begin
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    ctrl_mux_sel = 1'b0;
                    if (cnt <= FLUSH_CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign id_ex_write_en  = back_en;
    assign ex_mem_write_en = back_en;
    assign mem_wb_write_en = back_en;
    assign state_o         = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .en(stall_evt), .count(stall_cnt)
    );
    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .en(if_id_flush && !reset), .count(flush_cnt)
    );
    hazard_perf_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk(clk), .reset(reset), .en(mem_busy && !reset), .count(freeze_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller with a cycle-level reference model.
module tb_pipeline_hazard_controller;

    localparam int unsigned FC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_MemRead, branch_taken, mem_busy;
    logic       pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
    logic       if_id_flush, ctrl_mux_sel;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
        .mem_wb_write_en(mem_wb_write_en), .if_id_flush(if_id_flush),
        .ctrl_mux_sel(ctrl_mux_sel), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    typedef struct {
        bit          pc, ifid, back, fl, mux;
        bit [1:0]    st;
        int unsigned sc, fc, zc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining flush cycles and whether the previous cycle was a stall.
    int unsigned flush_left = 0;
    bit          stalled_prev = 1'b0;
    int unsigned m_sc = 0, m_fc = 0, m_zc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit busy, input bit br, input bit mr,
                        input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        reset = r; mem_busy = busy; branch_taken = br; ex_MemRead = mr;
        ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        e.st = (flush_left > 0) ? 2'd2 : (stalled_prev ? 2'd1 : 2'd0);
        e.sc = m_sc; e.fc = m_fc; e.zc = m_zc;
        e.pc = 1; e.ifid = 1; e.back = 1; e.fl = 0; e.mux = 1;
        if (r) begin
            e.pc = 0; e.ifid = 0; e.back = 0; e.fl = 1; e.mux = 0; e.st = 0;
            e.sc = 0; e.fc = 0; e.zc = 0;
            flush_left = 0; stalled_prev = 0; m_sc = 0; m_fc = 0; m_zc = 0;
        end else if (busy) begin
            e.pc = 0; e.ifid = 0; e.back = 0;
            m_zc++;
        end else if (flush_left > 0) begin
            e.fl = 1; e.mux = 0;
            flush_left--; stalled_prev = 0; m_fc++;
        end else if (br) begin
            e.fl = 1; e.mux = 0;
            flush_left = FC - 1; stalled_prev = 0; m_fc++;
        end else if (lu && !stalled_prev) begin
            e.pc = 0; e.ifid = 0; e.mux = 0;
            stalled_prev = 1; m_sc++;
        end else begin
            stalled_prev = 0;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_write_en", 32'(pc_write_en), 32'(e.pc));
                chk("if_id_write_en", 32'(if_id_write_en), 32'(e.ifid));
                chk("id_ex_write_en", 32'(id_ex_write_en), 32'(e.back));
                chk("ex_mem_write_en", 32'(ex_mem_write_en), 32'(e.back));
                chk("mem_wb_write_en", 32'(mem_wb_write_en), 32'(e.back));
                chk("if_id_flush", 32'(if_id_flush), 32'(e.fl));
                chk("ctrl_mux_sel", 32'(ctrl_mux_sel), 32'(e.mux));
                chk("state_o", 32'(state_o), 32'(e.st));
`ifdef HAZARD_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
                chk("freeze_cnt", freeze_cnt, e.zc);
`endif
            end
        end
    end

    initial begin : stimulus
        reset = 1; mem_busy = 0; branch_taken = 0; ex_MemRead = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs2, then x0 load
        step(0, 0, 0, 1, 5, 0, 5);
        idle(2);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(1);
        // branch, with a second branch ignored while flushing
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(3);
        // branch together with load-use
        step(0, 0, 1, 1, 7, 7, 0);
        idle(3);
        // freeze mid-flush with two flush cycles remaining
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        // load-use held for two cycles: one bubble only
        step(0, 0, 0, 1, 9, 9, 3);
        step(0, 0, 0, 1, 9, 9, 3);
        idle(2);
        // async reset between edges while flushing
        step(0, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        branch_taken = 0;
        #3;
        reset = 1;
        #1;
        chk("async_pc_write_en", 32'(pc_write_en), 32'd0);
        chk("async_id_ex_write_en", 32'(id_ex_write_en), 32'd0);
        chk("async_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("async_ctrl_mux_sel", 32'(ctrl_mux_sel), 32'd0);
        chk("async_state_o", 32'(state_o), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)));
        end
        idle(2);
        repeat (5) @(posedge clk);
        if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It combines three hazard sources into per-stage write enables, an IF/ID flush and the ID/EX control-mux select:
- load-use hazards,
- taken-branch redirects resolved in EX,
- data-memory wait.

It replaces ad-hoc per-stage gating and sits beside the pipeline registers in the top-level datapath.

Parameters:
FLUSH_CYCLES, 1, consecutive cycles IF/ID is flushed after a taken branch; legal 1..7
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 of instruction in ID
id_rs2  input  5  rs2 of instruction in ID
ex_rd  input  5  rd of instruction in EX
ex_MemRead  input  1  instruction in EX is a load
branch_taken  input  1  EX resolved a taken branch/jump this cycle
mem_busy  input  1  data memory not ready; freeze pipeline
pc_write_en  output  1  PC register load enable
if_id_write_en  output  1  IF/ID register load enable
id_ex_write_en  output  1  ID/EX register load enable
ex_mem_write_en  output  1  EX/MEM register load enable
mem_wb_write_en  output  1  MEM/WB register load enable
if_id_flush  output  1  clear IF/ID to NOP
ctrl_mux_sel  output  1  1 = pass decoded control into ID/EX; 0 = insert bubble (zero control)
state_o  output  2  current FSM state, for debug

Behaviour:
Reset
- Async reset: state=RUN, flush counter=0.
- While reset is high, all write enables are 0, if_id_flush=1, ctrl_mux_sel=0.
- Reset mid-flush or mid-stall abandons the operation. First cycle after release behaves as RUN.

Load-use detection (combinational)
- load_use = ex_MemRead && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- rd=x0 never causes a hazard.

FSM states: RUN=0, LOAD_STALL=1, FLUSH=2. Outputs are Mealy, same-cycle.

Priority within any cycle: mem_busy > branch_taken > load_use.

mem_busy=1 (any state)
- All five write enables 0, if_id_flush=0, ctrl_mux_sel=1.
- State and flush counter hold.
- branch_taken and load_use are ignored. Upstream holds them stable while frozen.

RUN, branch_taken=1
- if_id_flush=1, ctrl_mux_sel=0, all write enables 1.
- If FLUSH_CYCLES>1: counter<=FLUSH_CYCLES-1, go to FLUSH. Otherwise stay in RUN.
- A simultaneous load_use is discarded.

RUN, load_use=1
- pc_write_en=0, if_id_write_en=0, ctrl_mux_sel=0.
- id_ex/ex_mem/mem_wb enables stay 1.
- Go to LOAD_STALL.
- Latency: exactly one bubble per load-use.

RUN, otherwise
- All enables 1, flush=0, mux_sel=1.

LOAD_STALL
- load_use is masked for this cycle, so a stall never repeats back-to-back.
- branch_taken is handled as in RUN.
- Otherwise normal outputs. Next state is RUN (or FLUSH, per branch rule).

FLUSH
- if_id_flush=1, ctrl_mux_sel=0, all enables 1.
- Counter decrements each non-frozen cycle. Go to RUN when the counter reaches 1→0.
- branch_taken is ignored (wrong-path).

Illegal state encoding (3) recovers to RUN on the next clock with normal outputs.

Optional Feature:
Macro: HAZARD_PERF_CNT_EN.
Defined:
- Adds outputs stall_cnt[CNT_W], flush_cnt[CNT_W], freeze_cnt[CNT_W].
- Each counter increments on a cycle with load-use stall, with if_id_flush=1, or with mem_busy=1, respectively.
- Counters saturate at all-ones and clear on reset.

Undefined: ports and logic are absent; no other behaviour changes.

Decomposition:
Shared package hazard_pkg holds:
- state typedef/localparams RUN/LOAD_STALL/FLUSH;
- REG_X0=5'd0;
- FLUSH_CNT_W=3.

One natural sub-module: hazard_perf_counter (saturating counter, enable input, CNT_W parameter), instantiated 3× under the macro.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5, one cycle → pc_write_en=0, if_id_write_en=0, ctrl_mux_sel=0 for exactly 1 cycle; state_o=1 next cycle, then 0.
- x0 load: ex_MemRead=1, ex_rd=0, id_rs1=0 → no stall, all enables 1.
- Branch with FLUSH_CYCLES=3: branch_taken pulse → if_id_flush=1 for exactly 3 cycles. A second branch_taken in cycle 2 is ignored. Back to RUN.
- Simultaneous branch_taken and load_use → flush taken, no stall, pc_write_en=1.
- mem_busy=1 for 4 cycles during FLUSH with counter=2 → all enables 0 for 4 cycles, counter held; flush resumes for the remaining 2 cycles.
- Reset asserted mid-FLUSH asynchronously (between edges) → outputs go to reset values immediately. After release: state_o=0, enables 1. With HAZARD_PERF_CNT_EN, counters read 0.
